complex_mult_pipe: RTL

//   Parametrised, pipelined signed complex multiplier with valid/ready flow control.

---
 rtl/complex_mult_pipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/complex_mult_pipe.sv
// Pipelined signed complex multiplier, 3 stages, valid/ready, full precision.
// Build option: CMUL_CONJ_EN adds ConjB so the block can compute A*conj(B).
module complex_mult_pipe #(
  parameter int W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2*W-1:0]   InputMultiplier1,
  input  logic [2*W-1:0]   InputMultiplier2,
`ifdef CMUL_CONJ_EN
  input  logic             ConjB,
`endif
  output logic             OutValid,
  input  logic             OutReady,
  output logic [4*W+1:0]   MultiplicationResult,
  output logic [15:0]      SampleCount
);

  localparam int PW = 2*W+1;
  localparam int XW = W+1;

  logic                 r_v1, r_v2, r_v3;
  logic signed [W:0]    r_ar, r_ai, r_br, r_bi;
  logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [PW-1:0] r_re, r_im;
  logic [15:0]          r_cnt;

  logic                 w_rdy1, w_rdy2, w_rdy3;
  logic signed [W:0]    w_ar, w_ai, w_br, w_bi_x, w_bi;
  logic signed [PW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;

  function automatic logic signed [PW-1:0] sx(
    input logic signed [W:0] v
  );
    return {{(PW-XW){v[W]}}, v};
  endfunction

  assign w_rdy3  = ~r_v3 | OutReady;
  assign w_rdy2  = ~r_v2 | w_rdy3;
  assign w_rdy1  = ~r_v1 | w_rdy2;
  assign InReady = w_rdy1;

  assign w_ar   = {InputMultiplier1[2*W-1], InputMultiplier1[2*W-1:W]};
  assign w_ai   = {InputMultiplier1[W-1],   InputMultiplier1[W-1:0]};
  assign w_br   = {InputMultiplier2[2*W-1], InputMultiplier2[2*W-1:W]};
  assign w_bi_x = {InputMultiplier2[W-1],   InputMultiplier2[W-1:0]};

  // -(-2^(W-1)) needs the extra bit, which is why operands are W+1 wide
`ifdef CMUL_CONJ_EN
  assign w_bi = ConjB ? -w_bi_x : w_bi_x;
`else
  assign w_bi = w_bi_x;
`endif

  assign w_p_rr = sx(r_ar) * sx(r_br);
  assign w_p_ii = sx(r_ai) * sx(r_bi);
  assign w_p_ri = sx(r_ar) * sx(r_bi);
  assign w_p_ir = sx(r_ai) * sx(r_br);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_ar   <= '0;
      r_ai   <= '0;
      r_br   <= '0;
      r_bi   <= '0;
      r_p_rr <= '0;
      r_p_ii <= '0;
      r_p_ri <= '0;
      r_p_ir <= '0;
      r_re   <= '0;
      r_im   <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_rdy1) r_v1 <= InValid;
      if (w_rdy1 && InValid) begin
        r_ar <= w_ar;
        r_ai <= w_ai;
        r_br <= w_br;
        r_bi <= w_bi;
      end
      if (w_rdy2) r_v2 <= r_v1;
      if (w_rdy2 && r_v1) begin
        r_p_rr <= w_p_rr;
        r_p_ii <= w_p_ii;
        r_p_ri <= w_p_ri;
        r_p_ir <= w_p_ir;
      end
      if (w_rdy3) r_v3 <= r_v2;
      if (w_rdy3 && r_v2) begin
        r_re <= r_p_rr - r_p_ii;
        r_im <= r_p_ri + r_p_ir;
      end
      if (r_v3 && OutReady) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign OutValid             = r_v3;
  assign MultiplicationResult = {r_re, r_im};
  assign SampleCount          = r_cnt;

endmodule
